// File: rtl/hamming74_rx_decoder.sv
// ============================================================================
// Module   : hamming74_rx_decoder
// Purpose  : Serial Hamming(7,4) receiver: corrects single-bit errors, pairs
//            nibbles into bytes, and counts corrected codewords.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming74_rx_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sin_bit,
  input  logic             sin_strobe,
  input  logic             sync,
  input  logic             clr_stats,
  output logic [3:0]       nib_out,
  output logic [2:0]       syndrome,
  output logic             nib_valid,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:1]       cw_q, cw_d;
  logic             half_q, half_d;
  logic [3:0]       low_q, low_d;
  logic [3:0]       nib_q, nib_d;
  logic [2:0]       syn_q, syn_d;
  logic             nib_valid_q, nib_valid_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic [7:1]       cw_full;
  logic [2:0]       syn_now;
  logic [3:0]       nib_fix;
  logic             strobe;
  logic             complete;

  // The seventh bit is decoded straight off the input, so it never needs storage.
  always_comb begin
    cw_full    = {sin_bit, cw_q};
    syn_now[0] = cw_full[1] ^ cw_full[3] ^ cw_full[5] ^ cw_full[7];
    syn_now[1] = cw_full[2] ^ cw_full[3] ^ cw_full[6] ^ cw_full[7];
    syn_now[2] = cw_full[4] ^ cw_full[5] ^ cw_full[6] ^ cw_full[7];
    nib_fix[0] = cw_full[3] ^ (syn_now == 3'd3);
    nib_fix[1] = cw_full[5] ^ (syn_now == 3'd5);
    nib_fix[2] = cw_full[6] ^ (syn_now == 3'd6);
    nib_fix[3] = cw_full[7] ^ (syn_now == 3'd7);
    strobe     = ena & sin_strobe;
    complete   = strobe & ~sync & (bit_cnt_q == 3'd6);
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    cw_d         = cw_q;
    half_d       = half_q;
    low_d        = low_q;
    nib_d        = nib_q;
    syn_d        = syn_q;
    nib_valid_d  = 1'b0;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    err_d        = err_q;

    if (ena && sync) begin
      bit_cnt_d = 3'd0;
      half_d    = 1'b0;
    end

    if (strobe) begin
      if (sync) begin
        cw_d[1]   = sin_bit;
        bit_cnt_d = 3'd1;
      end else if (bit_cnt_q == 3'd6) begin
        bit_cnt_d   = 3'd0;
        nib_d       = nib_fix;
        syn_d       = syn_now;
        nib_valid_d = 1'b1;
        if (half_q) begin
          byte_d       = {nib_fix, low_q};
          byte_valid_d = 1'b1;
        end else begin
          low_d = nib_fix;
        end
        half_d = ~half_q;
      end else begin
        cw_d[bit_cnt_q + 3'd1] = sin_bit;
        bit_cnt_d              = bit_cnt_q + 3'd1;
      end
    end

    if (ena && clr_stats) begin
      err_d = '0;
    end else if (complete && (syn_now != 3'd0) && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q    <= 3'd0;
      cw_q         <= '0;
      half_q       <= 1'b0;
      low_q        <= 4'd0;
      nib_q        <= 4'd0;
      syn_q        <= 3'd0;
      nib_valid_q  <= 1'b0;
      byte_q       <= 8'd0;
      byte_valid_q <= 1'b0;
      err_q        <= '0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      cw_q         <= cw_d;
      half_q       <= half_d;
      low_q        <= low_d;
      nib_q        <= nib_d;
      syn_q        <= syn_d;
      nib_valid_q  <= nib_valid_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      err_q        <= err_d;
    end
  end

  assign nib_out    = nib_q;
  assign syndrome   = syn_q;
  assign nib_valid  = nib_valid_q;
  assign byte_out   = byte_q;
  assign byte_valid = byte_valid_q;
  assign err_cnt    = err_q;
  assign busy       = (bit_cnt_q != 3'd0);

endmodule

`default_nettype wire

// File: tb/tb_hamming74_rx_decoder.sv
// ============================================================================
// Module   : tb_hamming74_rx_decoder
// Purpose  : Scoreboard bench for hamming74_rx_decoder using directed codewords.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hamming74_rx_decoder;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b1;
  logic             sin_bit = 1'b0;
  logic             sin_strobe = 1'b0;
  logic             sync = 1'b0;
  logic             clr_stats = 1'b0;
  logic [3:0]       nib_out;
  logic [2:0]       syndrome;
  logic             nib_valid;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic [CNT_W-1:0] err_cnt;
  logic             busy;

  always #5 clk = ~clk;

  hamming74_rx_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sin_bit(sin_bit),
    .sin_strobe(sin_strobe), .sync(sync), .clr_stats(clr_stats),
    .nib_out(nib_out), .syndrome(syndrome), .nib_valid(nib_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .err_cnt(err_cnt), .busy(busy)
  );

  typedef struct packed {
    logic [3:0] nib;
    logic [2:0] syn;
    logic [7:0] err;
    logic       bv;
    logic [7:0] byt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  logic [3:0] low_m = 4'd0;
  bit   half_m = 1'b0;
  int   err_m = 0;

  // Hand-encoded codewords, bit i = position i+1 (p1,p2,d1,p3,d2,d3,d4).
  logic [6:0] enc [5] = '{7'b0000000, 7'b0101101, 7'b1010010, 7'b1010101, 7'b1111111};
  logic [3:0] nibs[5] = '{4'h0, 4'h5, 4'hA, 4'hB, 4'hF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [3:0] nib, input logic [2:0] syn, input bit clr);
    exp_t x;
    if (clr) err_m = 0;
    else if (syn != 3'd0 && err_m < 255) err_m++;
    x.nib = nib;
    x.syn = syn;
    x.err = err_m[7:0];
    if (half_m) begin
      x.bv  = 1'b1;
      x.byt = {nib, low_m};
    end else begin
      x.bv  = 1'b0;
      x.byt = 8'h00;
      low_m = nib;
    end
    half_m = ~half_m;
    exp_q.push_back(x);
  endtask

  task automatic cycle(input logic b, input logic stb, input logic sy, input logic clr);
    sin_bit = b; sin_strobe = stb; sync = sy; clr_stats = clr;
    @(posedge clk); #1;
    sin_strobe = 1'b0; sync = 1'b0; clr_stats = 1'b0;
  endtask

  task automatic send_cw(input logic [6:0] cw, input logic [3:0] nib, input int flip,
                         input bit clr_last, input bit first_sync, input int gap);
    logic [6:0] w;
    w = cw;
    if (flip > 0) w[flip-1] = ~w[flip-1];
    if (first_sync) half_m = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) push_exp(nib, 3'(flip), clr_last);
      cycle(w[i], 1'b1, (i == 0) && first_sync, (i == 6) && clr_last);
      repeat (gap) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (byte_valid && !nib_valid) check("byte_valid_without_nib_valid", 1, 0);
    if (nib_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_nib_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("nib_out", 32'(nib_out), 32'(e.nib));
        check("syndrome", 32'(syndrome), 32'(e.syn));
        check("err_cnt", 32'(err_cnt), 32'(e.err));
        check("byte_valid", 32'(byte_valid), 32'(e.bv));
        if (e.bv) check("byte_out", 32'(byte_out), 32'(e.byt));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_nib_out", 32'(nib_out), 0);
    check("reset_syndrome", 32'(syndrome), 0);
    check("reset_nib_valid", 32'(nib_valid), 0);
    check("reset_byte_out", 32'(byte_out), 0);
    check("reset_byte_valid", 32'(byte_valid), 0);
    check("reset_err_cnt", 32'(err_cnt), 0);
    check("reset_busy", 32'(busy), 0);

    send_cw(enc[3], 4'hB, 0, 0, 0, 0);            // clean 0xB
    send_cw(enc[3], 4'hB, 5, 0, 0, 1);            // position 5 flipped, gapped strobes
    send_cw(enc[1], 4'h5, 0, 0, 0, 0);            // 0x5 low half
    send_cw(enc[2], 4'hA, 0, 0, 0, 0);            // 0xA high half -> 0xA5
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("byte_out_hold", 32'(byte_out), 32'h A5);
    check("nib_out_hold", 32'(nib_out), 32'hA);

    // Leave a low half pending, then abort a partial codeword with sync.
    send_cw(enc[4], 4'hF, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(enc[2][i], 1'b1, 1'b0, 1'b0);
    check("busy_mid_codeword", 32'(busy), 1);
    send_cw(enc[3], 4'hB, 0, 0, 1, 0);
    check("busy_after_codeword", 32'(busy), 0);

    // Disabled cycles must ignore strobes, sync and clr_stats.
    for (int i = 0; i < 3; i++) cycle(enc[1][i], 1'b1, 1'b0, 1'b0);
    ena = 1'b0;
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    ena = 1'b1;
    check("busy_after_disabled", 32'(busy), 1);
    for (int i = 3; i < 7; i++) begin
      if (i == 6) push_exp(4'h5, 3'd0, 1'b0);
      cycle(enc[1][i], 1'b1, 1'b0, 1'b0);
    end

    for (int i = 0; i < 260; i++) send_cw(enc[i % 5], nibs[i % 5], (i % 7) + 1, 0, 0, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("err_cnt_saturated", 32'(err_cnt), 255);
    send_cw(enc[3], 4'hB, 2, 1, 0, 0);            // clr_stats wins over increment
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("err_cnt_cleared", 32'(err_cnt), 0);
    send_cw(enc[2], 4'hA, 7, 0, 0, 0);

    // Reset in the middle of a codeword.
    for (int i = 0; i < 4; i++) cycle(enc[3][i], 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    half_m = 1'b0;
    err_m = 0;
    check("busy_after_reset", 32'(busy), 0);
    check("err_cnt_after_reset", 32'(err_cnt), 0);
    check("byte_out_after_reset", 32'(byte_out), 0);
    send_cw(enc[3], 4'hB, 0, 0, 0, 0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("nib_out_final", 32'(nib_out), 32'hB);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hamming74_rx_decoder.md
HAMMING74_RX_DECODER -- requirements
Module: hamming74_rx_decoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of the corrected-error counter.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 The block SHALL have port ena, input, 1: when low, sin_strobe, sync and clr_stats are ignored and all state holds.
REQ-005 The block SHALL have port sin_bit, input, 1: serial codeword bit.
REQ-006 The block SHALL have port sin_strobe, input, 1: sin_bit is valid this cycle.
REQ-007 The block SHALL have port sync, input, 1: abort the partial codeword and the byte half.
REQ-008 The block SHALL have port clr_stats, input, 1: clear err_cnt.
REQ-009 The block SHALL have port nib_out, output, 4: corrected data nibble {d4,d3,d2,d1}.
REQ-010 The block SHALL have port syndrome, output, 3: syndrome of the last codeword.
REQ-011 The block SHALL have port nib_valid, output, 1: one-cycle pulse when a new nibble is presented.
REQ-012 The block SHALL have port byte_out, output, 8: assembled byte {high nibble, low nibble}.
REQ-013 The block SHALL have port byte_valid, output, 1: one-cycle pulse when a new byte is presented.
REQ-014 The block SHALL have port err_cnt, output, CNT_W: count of corrected codewords.
REQ-015 The block SHALL have port busy, output, 1: high while the bit counter is non-zero.

Function
REQ-016 The block SHALL sample sin_bit on each edge where ena=1 and sin_strobe=1; the first sampled bit is codeword position 1, the seventh is position 7.
REQ-017 The codeword layout SHALL be positions 1..7 = p1,p2,d1,p3,d2,d3,d4.
REQ-018 The bit counter SHALL run 0..6, advance once per sampled bit, and wrap to 0 on the edge sampling position 7.
REQ-019 The syndrome SHALL be s = {s3,s2,s1} with s1=c1^c3^c5^c7, s2=c2^c3^c6^c7, s3=c4^c5^c6^c7.
REQ-020 A non-zero s SHALL invert position s before data extraction; s=0 SHALL leave the codeword unchanged.
REQ-021 Decoding SHALL use the seven bits including the bit sampled that edge; nib_out and syndrome SHALL register on the edge sampling position 7.
REQ-022 nib_valid SHALL be high for exactly the following cycle (latency 1 clock from the 7th strobe edge).
REQ-023 nib_out and syndrome SHALL hold until the next completed codeword.
REQ-024 Nibbles SHALL alternate low half then high half.
REQ-025 On each high-half completion, byte_out SHALL update and byte_valid SHALL pulse in the same cycle as nib_valid.
REQ-026 byte_out SHALL hold between updates.
REQ-027 err_cnt SHALL increment by 1 on each completed codeword with s!=0.
REQ-028 err_cnt SHALL saturate at 2^CNT_W-1.
REQ-029 If clr_stats and an increment coincide, clr_stats SHALL win and err_cnt SHALL be 0.
REQ-030 sync SHALL clear the bit counter and the half flag and discard the partial codeword; nib_out, byte_out and err_cnt SHALL be unaffected.
REQ-031 If sync and sin_strobe coincide, the strobed bit SHALL be taken as position 1 of a new codeword (bit counter becomes 1).
REQ-032 busy SHALL equal (bit counter != 0).
REQ-033 The block SHALL detect and correct no double errors: every non-zero syndrome is treated as a single-bit error.

Reset
REQ-034 With rst_n=0 at an edge, the block SHALL set nib_out=0, syndrome=0, nib_valid=0, byte_out=0, byte_valid=0, err_cnt=0, busy=0, bit counter=0 and half flag=low.
REQ-035 Reset SHALL take priority over ena, sync, clr_stats and sin_strobe.
REQ-036 Reset mid-codeword SHALL discard the partial bits.

Verification
REQ-037 Send bits 1,0,1,0,1,0,1 (data 0xB) -> the cycle after the 7th strobe: nib_out=0xB, syndrome=0, nib_valid pulses 1 cycle, err_cnt=0.
REQ-038 Send 1,0,1,0,0,0,1 (position 5 flipped) -> nib_out=0xB, syndrome=5, err_cnt=1.
REQ-039 Send encoded 0x5 then encoded 0xA -> byte_valid pulses once with the second nib_valid, byte_out=0xA5.
REQ-040 Send 3 bits, assert sync with a strobe of bit 1, send 6 more bits of 0xB -> one nib_valid only, nib_out=0xB.
REQ-041 Force 260 single-error codewords with CNT_W=8 -> err_cnt=255; then assert clr_stats on an erroring codeword's 7th edge -> err_cnt=0.
REQ-042 Send 4 bits, assert rst_n=0 for one edge, then send a full codeword of 0xB -> busy=0 after reset, nib_out=0xB, and no spurious nib_valid.
